// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite bank of RW control registers and RO status registers.
// Define AXIL_REG_BANK_SLVERR_EN to answer RO/unmapped writes and unmapped reads with SLVERR.
module axil_reg_bank #(
  parameter int          NUM_RW_REGS = 4,
  parameter int          NUM_RO_REGS = 2,
  parameter logic [15:0] RO_BASE     = 16'h0100,
  parameter logic [31:0] RW_RESET    = 32'h0
) (
  input  logic                                         s_axi_aclk,
  input  logic                                         s_axi_aresetn,
  input  logic [15:0]                                  S_AXI_LITE_awaddr,
  input  logic [2:0]                                   S_AXI_LITE_awprot,
  input  logic                                         S_AXI_LITE_awvalid,
  output logic                                         S_AXI_LITE_awready,
  input  logic [31:0]                                  S_AXI_LITE_wdata,
  input  logic [3:0]                                   S_AXI_LITE_wstrb,
  input  logic                                         S_AXI_LITE_wvalid,
  output logic                                         S_AXI_LITE_wready,
  output logic [1:0]                                   S_AXI_LITE_bresp,
  output logic                                         S_AXI_LITE_bvalid,
  input  logic                                         S_AXI_LITE_bready,
  input  logic [15:0]                                  S_AXI_LITE_araddr,
  input  logic [2:0]                                   S_AXI_LITE_arprot,
  input  logic                                         S_AXI_LITE_arvalid,
  output logic                                         S_AXI_LITE_arready,
  output logic [31:0]                                  S_AXI_LITE_rdata,
  output logic [1:0]                                   S_AXI_LITE_rresp,
  output logic                                         S_AXI_LITE_rvalid,
  input  logic                                         S_AXI_LITE_rready,
  output logic [NUM_RW_REGS*32-1:0]                    o_rw_regs,
  output logic [NUM_RW_REGS-1:0]                       o_wr_pulse,
  input  logic [(NUM_RO_REGS > 0 ? NUM_RO_REGS : 1)*32-1:0] i_ro_regs
);
`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  localparam logic [13:0] RO_W = RO_BASE[15:2];
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  w_state_t    w_state, w_next;
  logic        aw_got, w_got;
  logic [13:0] aw_word;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rw_q [NUM_RW_REGS];
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        unused_ok;
  assign unused_ok = ^{S_AXI_LITE_awprot, S_AXI_LITE_arprot, S_AXI_LITE_awaddr[1:0],
                       S_AXI_LITE_araddr[1:0], i_ro_regs};
  // readies are gated by reset so they stay low while it is asserted
  assign S_AXI_LITE_awready = s_axi_aresetn && w_state == W_IDLE && !aw_got;
  assign S_AXI_LITE_wready  = s_axi_aresetn && w_state == W_IDLE && !w_got;
  assign S_AXI_LITE_arready = s_axi_aresetn && !S_AXI_LITE_rvalid;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) w_state <= W_IDLE;
    else w_state <= w_next;
  always_comb begin
    w_next = w_state;
    w_next = w_state == W_IDLE   ? (aw_got && w_got ? W_COMMIT : W_IDLE) :
             w_state == W_COMMIT ? W_RESP :
             (S_AXI_LITE_bready ? W_IDLE : W_RESP);
  end
  always_comb begin
    o_wr_pulse = '0;
    for (int i = 0; i < NUM_RW_REGS; i++)
      o_wr_pulse[i] = w_state == W_COMMIT && aw_word == 14'(i);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      aw_word           <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      S_AXI_LITE_bvalid <= 1'b0;
      S_AXI_LITE_bresp  <= 2'b00;
    end else begin
      if (S_AXI_LITE_awvalid && S_AXI_LITE_awready) begin
        aw_got  <= 1'b1;
        aw_word <= S_AXI_LITE_awaddr[15:2];
      end
      if (S_AXI_LITE_wvalid && S_AXI_LITE_wready) begin
        w_got   <= 1'b1;
        wdata_q <= S_AXI_LITE_wdata;
        wstrb_q <= S_AXI_LITE_wstrb;
      end
      if (w_state == W_COMMIT) begin
        aw_got            <= 1'b0;
        w_got             <= 1'b0;
        S_AXI_LITE_bvalid <= 1'b1;
        S_AXI_LITE_bresp  <= |o_wr_pulse ? 2'b00 : ERR;
      end
      if (w_state == W_RESP && S_AXI_LITE_bready) S_AXI_LITE_bvalid <= 1'b0;
    end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn)
      for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= RW_RESET;
    else
      for (int i = 0; i < NUM_RW_REGS; i++)
        for (int b = 0; b < 4; b++)
          if (o_wr_pulse[i] && wstrb_q[b]) rw_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_out
    assign o_rw_regs[32*g +: 32] = rw_q[g];
  end
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_RW_REGS; i++)
      if (S_AXI_LITE_araddr[15:2] == 14'(i)) begin
        rd_data = rw_q[i];
        rd_hit  = 1'b1;
      end
    for (int j = 0; j < NUM_RO_REGS; j++)
      if (S_AXI_LITE_araddr[15:2] == RO_W + 14'(j)) begin
        rd_data = i_ro_regs[32*j +: 32];
        rd_hit  = 1'b1;
      end
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      S_AXI_LITE_rvalid <= 1'b0;
      S_AXI_LITE_rdata  <= '0;
      S_AXI_LITE_rresp  <= 2'b00;
    end else if (S_AXI_LITE_arvalid && S_AXI_LITE_arready) begin
      S_AXI_LITE_rvalid <= 1'b1;
      S_AXI_LITE_rdata  <= rd_data;
      S_AXI_LITE_rresp  <= rd_hit ? 2'b00 : ERR;
    end else if (S_AXI_LITE_rready) begin
      S_AXI_LITE_rvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: directed checks of axil_reg_bank with default parameters.
module tb_axil_reg_bank;
`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic clk = 0, rst_n = 0;
  logic [15:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [127:0] o_rw_regs;
  logic [3:0] o_wr_pulse;
  logic [63:0] i_ro_regs = {32'h5555AAAA, 32'hCAFEF00D};
  int checks = 0, errors = 0, bv_rise = 0, rise0 = 0;
  int pulses[4] = '{0, 0, 0, 0};
  logic bv_prev = 0;
  always #5 clk = ~clk;
  axil_reg_bank dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .S_AXI_LITE_awaddr(awaddr), .S_AXI_LITE_awprot(awprot), .S_AXI_LITE_awvalid(awvalid),
    .S_AXI_LITE_awready(awready), .S_AXI_LITE_wdata(wdata), .S_AXI_LITE_wstrb(wstrb),
    .S_AXI_LITE_wvalid(wvalid), .S_AXI_LITE_wready(wready), .S_AXI_LITE_bresp(bresp),
    .S_AXI_LITE_bvalid(bvalid), .S_AXI_LITE_bready(bready), .S_AXI_LITE_araddr(araddr),
    .S_AXI_LITE_arprot(arprot), .S_AXI_LITE_arvalid(arvalid), .S_AXI_LITE_arready(arready),
    .S_AXI_LITE_rdata(rdata), .S_AXI_LITE_rresp(rresp), .S_AXI_LITE_rvalid(rvalid),
    .S_AXI_LITE_rready(rready), .o_rw_regs(o_rw_regs), .o_wr_pulse(o_wr_pulse),
    .i_ro_regs(i_ro_regs)
  );
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (o_wr_pulse[i]) pulses[i]++;
    if (bvalid && !bv_prev) bv_rise++;
    bv_prev = bvalid;
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_hs(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly);
    bit ad = 0, wd = 0, ah, wh;
    awaddr = a; wdata = d; wstrb = s;
    for (int c = 0; c < 40 && !(ad && wd); c++) begin
      if (!ad && c >= aw_dly) awvalid = 1;
      if (!wd && c >= w_dly) wvalid = 1;
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick;
      if (ah) begin ad = 1; awvalid = 0; end
      if (wh) begin wd = 1; wvalid = 0; end
    end
    chk("wr_handshake", {ad, wd}, 2'b11);
  endtask
  task automatic wr_b(input logic [1:0] exp_resp);
    int lat = 0;
    while (!bvalid && lat < 20) begin tick; lat++; end
    // handshake cycle, one idle cycle with both captured, commit cycle, then bvalid
    chk("b_latency", lat, 2);
    chk("bresp", {bvalid, bresp}, {1'b1, exp_resp});
    bready = 1; tick; bready = 0;
    chk("b_clear", bvalid, 0);
  endtask
  task automatic rd(input logic [15:0] a, input int hold, input logic [31:0] exp_d,
                    input logic [1:0] exp_r);
    int c = 0;
    araddr = a; arvalid = 1;
    while (!arready && c < 20) begin tick; c++; end
    tick; arvalid = 0;
    chk("r_data", {rvalid, rdata, rresp}, {1'b1, exp_d, exp_r});
    repeat (hold) begin
      tick;
      chk("r_hold", {rvalid, arready, rdata, rresp}, {2'b10, exp_d, exp_r});
    end
    rready = 1; tick; rready = 0;
    chk("r_clear", {rvalid, arready}, 2'b01);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, o_wr_pulse}, 0);
    chk("rst_regs", o_rw_regs, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);
    wr_hs(16'h0004, 32'h12345678, 4'hF, 0, 0);
    wr_b(2'b00);
    chk("pulse_r1", {pulses[0], pulses[1], pulses[2], pulses[3]}, {32'd0, 32'd1, 32'd0, 32'd0});
    rd(16'h0004, 0, 32'h12345678, 2'b00);
    wr_hs(16'h0000, 32'hAABBCCDD, 4'h5, 3, 0);
    wr_b(2'b00);
    chk("strb_reg0", o_rw_regs[31:0], 32'h00BB00DD);
    chk("bvalid_rises", bv_rise, 2);
    rd(16'h0003, 0, 32'h00BB00DD, 2'b00);
    wr_hs(16'h0008, 32'h11112222, 4'hF, 0, 0);
    tick; tick;
    chk("b_first", bvalid, 1);
    awaddr = 16'h000C; wdata = 32'h33334444; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    repeat (10) begin
      tick;
      chk("b_stall", {bvalid, awready, wready}, 3'b100);
    end
    bready = 1; tick; bready = 0;
    wr_hs(16'h000C, 32'h33334444, 4'hF, 0, 0);
    wr_b(2'b00);
    chk("regs_after_stall", o_rw_regs, {32'h33334444, 32'h11112222, 32'h12345678, 32'h00BB00DD});
    rd(16'h0100, 5, 32'hCAFEF00D, 2'b00);
    rd(16'h0104, 0, 32'h5555AAAA, 2'b00);
    wr_hs(16'h0200, 32'hDEADBEEF, 4'hF, 0, 0);
    wr_b(ERR);
    wr_hs(16'h0100, 32'hDEADBEEF, 4'hF, 0, 0);
    wr_b(ERR);
    rd(16'h0200, 0, 32'h0, ERR);
    rd(16'h0010, 0, 32'h0, ERR);
    chk("no_change", o_rw_regs, {32'h33334444, 32'h11112222, 32'h12345678, 32'h00BB00DD});
    chk("pulses_mapped", {pulses[0], pulses[1], pulses[2], pulses[3]}, {32'd1, 32'd1, 32'd1, 32'd1});
    wr_hs(16'h0000, 32'hFFFFFFFF, 4'h0, 0, 0);
    wr_b(2'b00);
    chk("zero_strb", {pulses[0], o_rw_regs[31:0]}, {32'd2, 32'h00BB00DD});
    rise0 = bv_rise;
    awaddr = 16'h0004; awvalid = 1; tick; awvalid = 0;
    chk("aw_only", {awready, wready}, 2'b01);
    rst_n = 0; #1;
    chk("async_clear", {awready, wready, arready, bvalid, rvalid, o_rw_regs}, 0);
    tick; tick;
    rst_n = 1;
    repeat (5) tick;
    chk("rst_abandon", {bv_rise, pulses[0], pulses[1], pulses[2], pulses[3]},
        {rise0, 32'd2, 32'd1, 32'd1, 32'd1});
    chk("rst_regs2", o_rw_regs, 0);
    rd(16'h0004, 0, 32'h0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
